id_ctrl_stage: RTL and testbench

- Parametrised ID-stage control block: decodes mode/opcode/S/cond, evaluates ARM condition codes against an internal NZCV status register, and registers all control plus operand fields into the ID/EX pipeline register.
- Supports stall and flush, with flush taking priority over stall.
- Annulled instructions become bubbles; a saturating counter tracks how many instructions failed their condition check.

---
 rtl/id_ctrl_stage.sv | 162 ++++++++++++++++
 tb/tb_id_ctrl_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ctrl_stage.sv
// ID-stage control: decodes the instruction fields, evaluates the ARM
// condition code against NZCV, and registers controls and operands into
// the ID/EX pipeline register. It supports stall and flush, and counts
// instructions that fail their condition check.
module id_ctrl_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [3:0]        cond,
  input  logic [1:0]        mode,
  input  logic [3:0]        opcode,
  input  logic              s,
  input  logic [REG_W-1:0]  dest_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic              stall,
  input  logic              flush,
  input  logic [3:0]        ex_status,
  input  logic              ex_status_we,
  output logic              valid_out,
  output logic [3:0]        exe_cmd_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              wb_en_out,
  output logic              b_out,
  output logic              s_out,
  output logic [REG_W-1:0]  dest_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] val_rn_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic [3:0]        status,
  output logic [CNT_W-1:0]  cond_fail_cnt
);

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  logic [3:0] exe_cmd;
  logic       mem_read, mem_write, wb_en, b_en, s_en;
  logic [3:0] flags;
  logic       cond_ok;
  logic       n_f, z_f, c_f, v_f;

  // Decode mode/opcode/S into the EX control bundle.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    exe_cmd   = CMD_NOP;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    wb_en     = 1'b0;
    b_en      = 1'b0;
    s_en      = 1'b0;
    unique case (mode)
      2'b00: begin
        s_en  = s;
        wb_en = 1'b1;
        unique case (opcode)
          4'b1101: exe_cmd = CMD_MOV;
          4'b1111: exe_cmd = CMD_MVN;
          4'b0100: exe_cmd = CMD_ADD;
          4'b0101: exe_cmd = CMD_ADC;
          4'b0010: exe_cmd = CMD_SUB;
          4'b0110: exe_cmd = CMD_SBC;
          4'b0000: exe_cmd = CMD_AND;
          4'b1100: exe_cmd = CMD_ORR;
          4'b0001: exe_cmd = CMD_EOR;
          4'b1010: begin exe_cmd = CMD_SUB; wb_en = 1'b0; end  // CMP
          4'b1000: begin exe_cmd = CMD_AND; wb_en = 1'b0; end  // TST
          default: wb_en = 1'b0;
        endcase
      end
      2'b01: begin
        if (opcode == 4'b0100) begin
          exe_cmd   = CMD_ADD;
          mem_read  = s;
          mem_write = ~s;
          wb_en     = s;
        end
      end
      2'b10: b_en = 1'b1;
      default: ;
    endcase
  end

  // Evaluate the condition field, bypassing a same-cycle status write.
  always_comb begin
    flags = ex_status_we ? ex_status : status;
    {n_f, z_f, c_f, v_f} = flags;
    unique case (cond)
      4'b0000: cond_ok = z_f;
      4'b0001: cond_ok = ~z_f;
      4'b0010: cond_ok = c_f;
      4'b0011: cond_ok = ~c_f;
      4'b0100: cond_ok = n_f;
      4'b0101: cond_ok = ~n_f;
      4'b0110: cond_ok = v_f;
      4'b0111: cond_ok = ~v_f;
      4'b1000: cond_ok = c_f & ~z_f;
      4'b1001: cond_ok = ~c_f | z_f;
      4'b1010: cond_ok = (n_f == v_f);
      4'b1011: cond_ok = (n_f != v_f);
      4'b1100: cond_ok = ~z_f & (n_f == v_f);
      4'b1101: cond_ok = z_f | (n_f != v_f);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // NZCV register; it follows EX regardless of stall or flush.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state is written with <= so every flop samples pre-edge values.
    if (!rst)              status <= 4'b0000;
    else if (ex_status_we) status <= ex_status;
  end

  // ID/EX register: flush beats stall, and annulled slots become bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || 1'b0) begin
      valid_out <= 1'b0; exe_cmd_out <= CMD_NOP; mem_read_out <= 1'b0;
      mem_write_out <= 1'b0; wb_en_out <= 1'b0; b_out <= 1'b0; s_out <= 1'b0;
      dest_out <= '0; pc_out <= '0; val_rn_out <= '0; val_rm_out <= '0;
    end else if (flush || (!stall && (!valid_in || !cond_ok))) begin
      valid_out <= 1'b0; exe_cmd_out <= CMD_NOP; mem_read_out <= 1'b0;
      mem_write_out <= 1'b0; wb_en_out <= 1'b0; b_out <= 1'b0; s_out <= 1'b0;
      dest_out <= '0; pc_out <= '0; val_rn_out <= '0; val_rm_out <= '0;
    end else if (!stall) begin
      valid_out     <= 1'b1;
      exe_cmd_out   <= exe_cmd;
      mem_read_out  <= mem_read;
      mem_write_out <= mem_write;
      wb_en_out     <= wb_en;
      b_out         <= b_en;
      s_out         <= s_en;
      dest_out      <= dest_in;
      pc_out        <= pc_in;
      val_rn_out    <= val_rn_in;
      val_rm_out    <= val_rm_in;
    end
  end

  // Saturating count of real instructions annulled by their condition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cond_fail_cnt <= '0;
    else if (valid_in && !cond_ok && !flush && !stall && (cond_fail_cnt != '1))
      cond_fail_cnt <= cond_fail_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Self-checking bench for id_ctrl_stage: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_id_ctrl_stage;

  localparam int DATA_W = 32;
  localparam int REG_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in, s, stall, flush, ex_status_we;
  logic [3:0]        cond, opcode, ex_status;
  logic [1:0]        mode;
  logic [REG_W-1:0]  dest_in;
  logic [DATA_W-1:0] pc_in, val_rn_in, val_rm_in;

  logic              valid_out, mem_read_out, mem_write_out, wb_en_out, b_out, s_out;
  logic [3:0]        exe_cmd_out, status;
  logic [REG_W-1:0]  dest_out;
  logic [DATA_W-1:0] pc_out, val_rn_out, val_rm_out;
  logic [15:0]       cond_fail_cnt;

  logic              d2_valid, d2_mr, d2_mw, d2_wb, d2_b, d2_s;
  logic [3:0]        d2_cmd, d2_status;
  logic [REG_W-1:0]  d2_dest;
  logic [DATA_W-1:0] d2_pc, d2_rn, d2_rm;
  logic [1:0]        d2_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ctrl_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .cond(cond), .mode(mode),
    .opcode(opcode), .s(s), .dest_in(dest_in), .pc_in(pc_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .stall(stall), .flush(flush),
    .ex_status(ex_status), .ex_status_we(ex_status_we),
    .valid_out(valid_out), .exe_cmd_out(exe_cmd_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .wb_en_out(wb_en_out), .b_out(b_out),
    .s_out(s_out), .dest_out(dest_out), .pc_out(pc_out), .val_rn_out(val_rn_out),
    .val_rm_out(val_rm_out), .status(status), .cond_fail_cnt(cond_fail_cnt)
  );

  id_ctrl_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .cond(cond), .mode(mode),
    .opcode(opcode), .s(s), .dest_in(dest_in), .pc_in(pc_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .stall(stall), .flush(flush),
    .ex_status(ex_status), .ex_status_we(ex_status_we),
    .valid_out(d2_valid), .exe_cmd_out(d2_cmd), .mem_read_out(d2_mr),
    .mem_write_out(d2_mw), .wb_en_out(d2_wb), .b_out(d2_b),
    .s_out(d2_s), .dest_out(d2_dest), .pc_out(d2_pc), .val_rn_out(d2_rn),
    .val_rm_out(d2_rm), .status(d2_status), .cond_fail_cnt(d2_cnt)
  );

  // Reference model state.
  typedef struct {
    bit       valid, mr, mw, wb, b, s;
    bit [3:0] cmd;
    bit [REG_W-1:0]  dest;
    bit [DATA_W-1:0] pc, rn, rm;
  } idex_t;

  idex_t    m;
  bit [3:0] m_status;
  int       m_cnt16, m_cnt2;

  bit [3:0] alu_cmd_of [16];
  bit       alu_mapped [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Even condition codes test a predicate; the following odd code is its negation.
  function automatic bit cond_true(input bit [3:0] c, input bit [3:0] f);
    bit n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic idex_t bubble();
    idex_t r;
    r = '{default: '0};
    return r;
  endfunction

  task automatic model_reset();
    m = bubble();
    m_status = 4'd0;
    m_cnt16 = 0;
    m_cnt2 = 0;
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    bit [3:0] f;
    bit ok;
    idex_t r;
    f  = ex_status_we ? ex_status : m_status;
    ok = cond_true(cond, f);
    if (flush) m = bubble();
    else if (stall) ;
    else if (!valid_in || !ok) m = bubble();
    else begin
      r = bubble();
      r.valid = 1; r.dest = dest_in; r.pc = pc_in; r.rn = val_rn_in; r.rm = val_rm_in;
      if (mode == 2'b00) begin
        r.s = s;
        if (alu_mapped[opcode]) begin
          r.cmd = alu_cmd_of[opcode];
          r.wb  = !(opcode == 4'b1010 || opcode == 4'b1000);
        end
      end else if (mode == 2'b01 && opcode == 4'b0100) begin
        r.cmd = 4'b0010; r.mr = s; r.mw = !s; r.wb = s;
      end else if (mode == 2'b10) begin
        r.b = 1;
      end
      m = r;
    end
    if (valid_in && !ok && !flush && !stall) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    if (ex_status_we) m_status = ex_status;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, valid_out, m.valid);
    check({tag, ".cmd"}, exe_cmd_out, m.cmd);
    check({tag, ".mem_read"}, mem_read_out, m.mr);
    check({tag, ".mem_write"}, mem_write_out, m.mw);
    check({tag, ".wb"}, wb_en_out, m.wb);
    check({tag, ".b"}, b_out, m.b);
    check({tag, ".s"}, s_out, m.s);
    check({tag, ".dest"}, dest_out, m.dest);
    check({tag, ".pc"}, pc_out, m.pc);
    check({tag, ".rn"}, val_rn_out, m.rn);
    check({tag, ".rm"}, val_rm_out, m.rm);
    check({tag, ".status"}, status, m_status);
    check({tag, ".cnt"}, cond_fail_cnt, m_cnt16);
    check({tag, ".cnt2"}, d2_cnt, m_cnt2);
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    valid_in = 0; cond = 4'b1110; mode = 2'b00; opcode = 4'b0000; s = 0;
    dest_in = '0; pc_in = '0; val_rn_in = '0; val_rm_in = '0;
    stall = 0; flush = 0; ex_status = 4'd0; ex_status_we = 0;
  endtask

  task automatic instr(input bit [1:0] md, input bit [3:0] op, input bit sb,
                       input bit [3:0] cc, input bit [REG_W-1:0] d);
    valid_in = 1; mode = md; opcode = op; s = sb; cond = cc; dest_in = d;
    pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
  endtask

  initial begin
    alu_mapped = '{default: 0};
    alu_cmd_of = '{default: 0};
    alu_mapped[4'b1101] = 1; alu_cmd_of[4'b1101] = 4'b0001;
    alu_mapped[4'b1111] = 1; alu_cmd_of[4'b1111] = 4'b1001;
    alu_mapped[4'b0100] = 1; alu_cmd_of[4'b0100] = 4'b0010;
    alu_mapped[4'b0101] = 1; alu_cmd_of[4'b0101] = 4'b0011;
    alu_mapped[4'b0010] = 1; alu_cmd_of[4'b0010] = 4'b0100;
    alu_mapped[4'b0110] = 1; alu_cmd_of[4'b0110] = 4'b0101;
    alu_mapped[4'b0000] = 1; alu_cmd_of[4'b0000] = 4'b0110;
    alu_mapped[4'b1100] = 1; alu_cmd_of[4'b1100] = 4'b0111;
    alu_mapped[4'b0001] = 1; alu_cmd_of[4'b0001] = 4'b1000;
    alu_mapped[4'b1010] = 1; alu_cmd_of[4'b1010] = 4'b0100;
    alu_mapped[4'b1000] = 1; alu_cmd_of[4'b1000] = 4'b0110;

    // Reset state.
    idle();
    rst = 0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk) rst = 1;

    // ADD, always.
    @(posedge clk); #1;
    instr(2'b00, 4'b0100, 0, 4'b1110, 4'd3);
    cycle("add");
    check("add.cmd_const", exe_cmd_out, 4'b0010);
    check("add.wb_const", wb_en_out, 1'b1);

    // LDR then STR.
    instr(2'b01, 4'b0100, 1, 4'b1110, 4'd5);
    cycle("ldr");
    check("ldr.mem_read_const", mem_read_out, 1'b1);
    check("ldr.dest_const", dest_out, 4'd5);
    instr(2'b01, 4'b0100, 0, 4'b1110, 4'd5);
    cycle("str");
    check("str.mem_write_const", mem_write_out, 1'b1);
    check("str.wb_const", wb_en_out, 1'b0);

    // BEQ with same-cycle Z bypass, then BNE annulled.
    instr(2'b10, 4'b0000, 0, 4'b0000, 4'd0);
    ex_status = 4'b0100; ex_status_we = 1;
    cycle("beq_bypass");
    check("beq.b_const", b_out, 1'b1);
    ex_status = 4'b0000; ex_status_we = 0;
    instr(2'b10, 4'b0000, 0, 4'b0001, 4'd0);
    ex_status = 4'b0100; ex_status_we = 1;
    cycle("bne_fail");
    check("bne.cnt_const", cond_fail_cnt, 16'd1);
    check("bne.valid_const", valid_out, 1'b0);
    ex_status_we = 0;

    // CMP with S, then three stalled cycles with changing inputs.
    instr(2'b00, 4'b1010, 1, 4'b1110, 4'd7);
    cycle("cmp");
    check("cmp.cmd_const", exe_cmd_out, 4'b0100);
    check("cmp.s_const", s_out, 1'b1);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      instr(2'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
      cycle("stall");
      check("stall.cmd_const", exe_cmd_out, 4'b0100);
    end
    flush = 1;
    cycle("stall_flush");
    check("stall_flush.valid_const", valid_out, 1'b0);
    stall = 0; flush = 0;

    // Asynchronous reset mid-cycle while a real instruction sits in EX.
    instr(2'b00, 4'b1101, 0, 4'b1110, 4'd9);
    ex_status = 4'b1011; ex_status_we = 1;
    cycle("pre_rst");
    ex_status_we = 0;
    #2 rst = 0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk) rst = 1;

    // Four consecutive condition failures: narrow counter runs 1,2,3,3.
    for (int i = 0; i < 4; i++) begin
      instr(2'b00, 4'b0100, 0, 4'b1111, 4'd1);
      cycle("sat");
      check("sat.cnt2_const", d2_cnt, (i < 3) ? 2'(i + 1) : 2'd3);
    end

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      instr(2'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(1, 2) == 1 && mode == 2'b01) opcode = 4'b0100;
      valid_in     = ($urandom_range(0, 7) != 0);
      stall        = ($urandom_range(0, 4) == 0);
      flush        = ($urandom_range(0, 7) == 0);
      ex_status_we = ($urandom_range(0, 2) == 0);
      ex_status    = 4'($urandom);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
